// File: rtl/bus_arbiter4x16_pkg.sv
// Shared types and helpers for the four-way round-robin bus arbiter.
package bus_arbiter4x16_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int HOLD_W = 3;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First set bit of reqs, searching start, start+1, start+2, start+3 (mod 4).
  function automatic pick_t pick_first(input logic [3:0] reqs, input logic [1:0] start);
    pick_t      r;
    logic [1:0] idx;
    r = '0;
    // Walk the order backwards so the earliest hit overwrites later ones.
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (reqs[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4x16_mux4way16.sv
// Four-way 16-bit data multiplexer driven by the arbiter's owner index.
module Mux4Way16 (
  output logic [15:0] out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel
);

  // Pure combinational select; no storage on the data path.
  always_comb begin
    out = a;
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/bus_arbiter4x16.sv
// Round-robin arbiter sharing one 16-bit bus among four requesters,
// with a per-owner hold limit that only bites while someone else waits.
//
// state   | meaning
// --------+------------------------------------------
// ST_IDLE | no owner, grant=0, out forced to zero
// ST_BUSY | owner is sel, out follows that source
module bus_arbiter4x16
  import bus_arbiter4x16_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  output logic [3:0]  grant,
  output logic [1:0]  sel,
  output logic        out_valid,
  output logic [15:0] out
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_e        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [3:0]  others;
  logic [1:0]  after_owner;
  pick_t       pick_idle;
  pick_t       pick_next;
  logic [15:0] mux_out;

  // The releasing/holding owner is never a candidate for its own successor.
  assign others      = req & ~grant_q;
  assign after_owner = sel_q + 2'd1;
  assign pick_idle   = pick_first(req, ptr_q);
  assign pick_next   = pick_first(others, after_owner);

  // State and owner registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  // Next owner: first grant from idle, hand-over on release, or fairness preemption.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_idle.found) begin
          state_d = ST_BUSY;
          sel_d   = pick_idle.idx;
          grant_d = onehot4(pick_idle.idx);
          valid_d = 1'b1;
          hold_d  = HOLD_ONE;
        end
      end
      ST_BUSY: begin
        if (!req[sel_q]) begin
          // Release: hand straight to the next waiter, or go idle keeping sel.
          ptr_d = after_owner;
          if (pick_next.found) begin
            sel_d   = pick_next.idx;
            grant_d = onehot4(pick_next.idx);
            hold_d  = HOLD_ONE;
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_MAX && pick_next.found) begin
          ptr_d   = after_owner;
          sel_d   = pick_next.idx;
          grant_d = onehot4(pick_next.idx);
          hold_d  = HOLD_ONE;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  Mux4Way16 u_mux (
    .out (mux_out),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel_q)
  );

  assign out       = mux_out & {16{valid_q}};
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter4x16.sv
module tb_bus_arbiter4x16;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] a, b, c, d;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        out_valid;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  bus_arbiter4x16 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner as an integer (-1 = nobody), plain modular arithmetic.
  typedef struct {
    int owner;
    int sel;
  } exp_t;

  exp_t exp_q[$];
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_hold  = 0;
  int   m_sel   = 0;

  function automatic int first_from(input logic [3:0] bits, input int start);
    for (int k = 0; k < 4; k++) begin
      if (bits[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [3:0] others;
    exp_t e;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
      exp_q.delete();
    end else begin
      if (m_owner < 0) begin
        if (req != 4'b0) begin
          m_owner = first_from(req, m_ptr);
          m_hold  = 1;
        end
      end else begin
        others = req;
        others[m_owner] = 1'b0;
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = first_from(others, m_ptr);
          m_hold  = (m_owner >= 0) ? 1 : 0;
        end else if (m_hold >= MAX_HOLD && others != 4'b0) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = first_from(others, m_ptr);
          m_hold  = 1;
        end else if (m_hold < MAX_HOLD) begin
          m_hold++;
        end
      end
      if (m_owner >= 0) m_sel = m_owner;
      e.owner = m_owner;
      e.sel   = m_sel;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] eo;
    logic [3:0]  eg;
    if (!reset && exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      eg = (e.owner >= 0) ? (4'b0001 << e.owner) : 4'b0000;
      case (e.owner)
        0:       eo = a;
        1:       eo = b;
        2:       eo = c;
        3:       eo = d;
        default: eo = 16'h0000;
      endcase
      chk("grant", 32'(grant), 32'(eg));
      chk("sel", 32'(sel), 32'(e.sel));
      chk("out_valid", 32'(out_valid), 32'(e.owner >= 0));
      chk("out", 32'(out), 32'(eo));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 4'b0; a = 16'h0101; b = 16'h0202; c = 16'h0303; d = 16'h0404;
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Single requester c, then release.
    req = 4'b0100; c = 16'hAAAA;
    tick(1);
    chk("c_grant", 32'(grant), 32'h4);
    chk("c_out", 32'(out), 32'hAAAA);
    tick(2);
    req = 4'b0000;
    tick(1);
    chk("c_rel_grant", 32'(grant), 32'h0);
    chk("c_rel_out", 32'(out), 32'h0);

    // b owns the bus; data changes on b show up, a changes never do.
    a = 16'h1234; b = 16'h9876; req = 4'b0010;
    tick(2);
    b = 16'h5555; #1;
    chk("b_live", 32'(out), 32'h5555);
    a = 16'hDEAD; #1;
    chk("a_hidden", 32'(out), 32'h5555);

    // Lone b holds for 20 cycles, then a is preempted in on the next edge.
    tick(20);
    chk("b_lone", 32'(grant), 32'h2);
    req = 4'b0011;
    tick(1);
    chk("b_preempt", 32'(grant), 32'h1);
    req = 4'b0000;
    tick(2);

    // d releases while a,b wait: wrap to a with no idle bubble.
    req = 4'b1000;
    tick(3);
    req = 4'b0011;
    tick(1);
    chk("wrap_a", 32'(grant), 32'h1);

    // All four requesting: rotate every MAX_HOLD cycles.
    req = 4'b1111;
    tick(40);

    // Async reset mid-BUSY, then restart from ptr 0.
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_out", 32'(out), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("post_rst_grant", 32'(grant), 32'h1);
    chk("post_rst_sel", 32'(sel), 32'h0);
    chk("post_rst_out", 32'(out), 32'(a));

    // Randomized traffic with sticky requests and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 35) req = 4'($urandom_range(0, 15));
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      if (i == 250 || i == 480) begin
        #2 reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick(1);
    end

    req = 4'b0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
